// File: rtl/simplecpu_gen2.sv
// simplecpu_gen2: parametrised accumulator CPU with a unified program/data RAM loaded from an external port.
// Optional single-step gating is compiled in when SIMPLECPU_STEP_EN is defined.
module simplecpu_gen2 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
`ifdef SIMPLECPU_STEP_EN
    input  logic              step_i,
`endif
    input  logic              load_ram_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              halted_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              flag_zero_o,
    output logic              flag_carry_o
);
    // state  | meaning
    // S_EXEC | fetch/execute one instruction at pc
    // S_ALU  | second cycle of ADD/SUB, updates A and flags
    // S_HALT | stopped after HLT, left only by reset
    typedef enum logic [1:0] {S_EXEC, S_ALU, S_HALT} state_t;

    localparam int         DEPTH  = 2**ADDR_W;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'h8;
    localparam logic [3:0] OP_HLT = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_JNZ = 4'hB;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic              outv_q, outv_d, z_q, z_d, c_q, c_d, sub_q, sub_d;

    logic [DATA_W-1:0] instr;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic              advance;
    logic [DATA_W:0]   alu_sum;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign instr   = mem_q[pc_q];
    assign opcode  = instr[DATA_W-1 -: 4];
    assign operand = instr[ADDR_W-1:0];

    // A load cycle stalls the whole core; reset blocks STA from touching RAM.
`ifdef SIMPLECPU_STEP_EN
    assign advance = reset_i && !load_ram_i && step_i;
`else
    assign advance = reset_i && !load_ram_i;
`endif

    assign alu_sum = sub_q ? ({1'b0, a_q} + {1'b0, ~b_q} + {{DATA_W{1'b0}}, 1'b1})
                           : ({1'b0, a_q} + {1'b0, b_q});

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        out_d     = out_q;
        outv_d    = 1'b0;
        z_d       = z_q;
        c_d       = c_q;
        sub_d     = sub_q;
        mem_we    = load_ram_i;
        mem_waddr = load_addr_i;
        mem_wdata = load_data_i;
        if (advance) begin
            unique case (state_q)
                S_EXEC: begin
                    pc_d = pc_q + ADDR_W'(1);
                    case (opcode)
                        OP_LDA: a_d = mem_q[operand];
                        OP_ADD, OP_SUB: begin
                            b_d     = mem_q[operand];
                            sub_d   = (opcode == OP_SUB);
                            pc_d    = pc_q;
                            state_d = S_ALU;
                        end
                        OP_STA: begin
                            mem_we    = 1'b1;
                            mem_waddr = operand;
                            mem_wdata = a_q;
                        end
                        OP_LDI: a_d = DATA_W'(operand);
                        OP_JMP: pc_d = operand;
                        OP_JZ:  if (z_q)  pc_d = operand;
                        OP_JC:  if (c_q)  pc_d = operand;
                        OP_JNZ: if (!z_q) pc_d = operand;
                        OP_OUT: begin
                            out_d  = a_q;
                            outv_d = 1'b1;
                        end
                        OP_HLT: begin
                            pc_d    = pc_q;
                            state_d = S_HALT;
                        end
                        default: ;
                    endcase
                end
                S_ALU: begin
                    c_d     = alu_sum[DATA_W];
                    a_d     = alu_sum[DATA_W-1:0];
                    z_d     = (alu_sum[DATA_W-1:0] == '0);
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= S_EXEC;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            outv_q  <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            outv_q  <= outv_d;
            z_q     <= z_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
        end
    end

    // RAM contents survive reset; loads are accepted in every state.
    always_ff @(posedge clock_i) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign out_data_o   = out_q;
    assign out_valid_o  = outv_q;
    assign halted_o     = (state_q == S_HALT);
    assign pc_o         = pc_q;
    assign flag_zero_o  = z_q;
    assign flag_carry_o = c_q;

endmodule
